// File: rtl/iq_ctl_pkg.sv
// Shared defaults for the instruction-queue controller (depth, widths, port counts).
package iq_ctl_pkg;
    localparam int IQ_DEPTH     = 16;
    localparam int IQ_AW        = $clog2(IQ_DEPTH);
    localparam int IQ_DATA_W    = 64;
    localparam int IQ_ISS_PORTS = 3;
    localparam int IQ_WB_PORTS  = 3;
    localparam int IQ_COMMIT_W  = 2;
endpackage

// File: rtl/iq_ctl_commit_sel.sv
// Commit selector: from head, takes the longest run of valid & finished entries,
// capped at COMMIT_W, and reports it as a bit mask plus a count.
module iq_commit_sel
    import iq_ctl_pkg::*;
#(
    parameter int DEPTH    = IQ_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int COMMIT_W = IQ_COMMIT_W,
    parameter int CW       = $clog2(COMMIT_W) + 1
) (
    input  logic [AW-1:0]    head_i,
    input  logic [DEPTH-1:0] valid_i,
    input  logic [DEPTH-1:0] finished_i,
    output logic [DEPTH-1:0] commit_bit_o,
    output logic [CW-1:0]    commit_cnt_o
);
    logic          run;
    logic [AW-1:0] idx;

    always_comb begin
        commit_bit_o = '0;
        commit_cnt_o = '0;
        run          = 1'b1;
        idx          = head_i;
        // Index arithmetic wraps mod DEPTH, so a run may cross DEPTH-1 -> 0.
        for (int k = 0; k < COMMIT_W; k++) begin
            idx = head_i + AW'(k);
            if (run && valid_i[idx] && finished_i[idx]) begin
                commit_bit_o[idx] = 1'b1;
                commit_cnt_o      = commit_cnt_o + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end
endmodule

// File: rtl/iq_ctl.sv
// Instruction-queue controller: circular buffer with issue/finish marks, in-order
// multi-wide commit and, when IQ_FLUSH_EN is defined, mispredict flush.
module iq_ctl
    import iq_ctl_pkg::*;
#(
    parameter int DEPTH     = IQ_DEPTH,
    parameter int AW        = $clog2(DEPTH),
    parameter int DATA_W    = IQ_DATA_W,
    parameter int ISS_PORTS = IQ_ISS_PORTS,
    parameter int WB_PORTS  = IQ_WB_PORTS,
    parameter int COMMIT_W  = IQ_COMMIT_W,
    parameter int CW        = $clog2(COMMIT_W) + 1
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic [AW-1:0]           in_pos,
    input  logic [ISS_PORTS-1:0]    iss_valid,
    input  logic [ISS_PORTS*AW-1:0] iss_pos,
    input  logic [WB_PORTS-1:0]     wb_valid,
    input  logic [WB_PORTS*AW-1:0]  wb_pos,
    input  logic                    flush,
    input  logic [AW-1:0]           flush_pos,
    output logic [DEPTH*DATA_W-1:0] entry_data,
    output logic [DEPTH-1:0]        valid_o,
    output logic [DEPTH-1:0]        issued_o,
    output logic [DEPTH-1:0]        finished_o,
    output logic [DEPTH-1:0]        commit_bit,
    output logic [CW-1:0]           commit_cnt,
    output logic [AW-1:0]           head_o,
    output logic [AW-1:0]           tail_o,
    output logic [AW:0]             count_o
);
    logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [AW:0]       count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d, issued_q, issued_d, finished_q, finished_d;
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [DEPTH-1:0]  squash, ins_hit, iss_hit, wb_hit, clr, commit_valid;
    logic [AW:0]       sq_cnt;
    logic              full, do_ins;

    assign full   = (count_q == (AW+1)'(DEPTH));
    assign do_ins = in_valid & in_ready;

`ifdef IQ_FLUSH_EN
    logic [AW-1:0] rel_fp;
    assign rel_fp = flush_pos - head_q;

    // Younger than flush_pos means a larger head-relative age.
    always_comb begin
        squash = '0;
        sq_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush && valid_q[i] && ((AW'(i) - head_q) > rel_fp))
                squash[i] = 1'b1;
            sq_cnt = sq_cnt + (AW+1)'(squash[i]);
        end
    end

    assign in_ready = ~full & ~flush;
    assign tail_d   = flush ? (flush_pos + AW'(1)) : (tail_q + AW'(do_ins));
`else
    logic unused_flush;
    assign unused_flush = ^{flush, flush_pos};
    assign squash   = '0;
    assign sq_cnt   = '0;
    assign in_ready = ~full;
    assign tail_d   = tail_q + AW'(do_ins);
`endif

    // Squashed entries are kept out of the commit run so the two never overlap.
    assign commit_valid = valid_q & ~squash;

    iq_commit_sel #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .COMMIT_W (COMMIT_W),
        .CW       (CW)
    ) u_commit_sel (
        .head_i       (head_q),
        .valid_i      (commit_valid),
        .finished_i   (finished_q),
        .commit_bit_o (commit_bit),
        .commit_cnt_o (commit_cnt)
    );

    always_comb begin
        iss_hit = '0;
        wb_hit  = '0;
        for (int k = 0; k < ISS_PORTS; k++)
            if (iss_valid[k]) iss_hit[iss_pos[k*AW +: AW]] = 1'b1;
        for (int k = 0; k < WB_PORTS; k++)
            if (wb_valid[k]) wb_hit[wb_pos[k*AW +: AW]] = 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign ins_hit[gi]    = do_ins && (tail_q == AW'(gi));
            assign clr[gi]        = commit_bit[gi] | squash[gi];
            assign valid_d[gi]    = ins_hit[gi] | (valid_q[gi] & ~clr[gi]);
            assign issued_d[gi]   = ~ins_hit[gi] & ~clr[gi] &
                                    (issued_q[gi] | (valid_q[gi] & iss_hit[gi]));
            assign finished_d[gi] = ~ins_hit[gi] & ~clr[gi] &
                                    (finished_q[gi] | (valid_q[gi] & wb_hit[gi]));
            assign entry_data[gi*DATA_W +: DATA_W] = data_q[gi];
        end
    endgenerate

    assign head_d  = head_q + AW'(commit_cnt);
    assign count_d = count_q + (AW+1)'(do_ins) - (AW+1)'(commit_cnt) - sq_cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            issued_q   <= '0;
            finished_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            issued_q   <= issued_d;
            finished_q <= finished_d;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (ins_hit[i]) data_q[i] <= in_data;
        end
    end

    assign in_pos     = tail_q;
    assign head_o     = head_q;
    assign tail_o     = tail_q;
    assign count_o    = count_q;
    assign valid_o    = valid_q;
    assign issued_o   = issued_q;
    assign finished_o = finished_q;
endmodule
